// File: rtl/uart_prot_pkg.sv
// Shared types and constants for the UART protocol
// receive path.
package uart_prot_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    WAIT_ADDR = 3'd2,
    RECV      = 3'd3,
    DROP      = 3'd4,
    DONE      = 3'd5
  } rx_state_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_LEN = 1;
  localparam int ERR_TMO = 2;

  localparam logic [7:0] BCAST_ADDR_DEF = 8'hFF;

  function automatic logic addr_hit(
    input logic [7:0] b,
    input logic [7:0] self_a,
    input logic [7:0] bcast_a
  );
    return (b == self_a) || (b == bcast_a);
  endfunction

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// Inter-byte timeout counter: saturating count with
// clear/enable and a terminal-count pulse.
module uart_rx_timeout_cnt #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic glb_clk,
  input  logic glb_rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // Count enabled cycles, stop at the terminal value
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TERM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && !clr && (cnt == TERM);

endmodule

// File: rtl/uart_protocal_rx_stm.sv
// Receive-side frame parser: address, payload, stop
// byte; forwards accepted payload to the Rx FIFO.
module uart_protocal_rx_stm
  import uart_prot_pkg::*;
#(
  parameter logic [7:0] BCAST_ADDR = BCAST_ADDR_DEF,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       glb_clk,
  input  logic       glb_rstn,
  input  logic       CFG_PROT_ctrl_Rxen,
  input  logic [7:0] CFG_PROT_data_self_addr,
  input  logic [7:0] CFG_PROT_data_stop_frame,
  input  logic       CORE_PROT_w_en,
  input  logic [7:0] CORE_PROT_data_rx_data,
  input  logic       Rx_FIFO_full,
  output logic       PROT_CFG_ctrl_rx_w_en,
  output logic [7:0] PROT_CFG_data_rx_data,
  output logic       PROT_CFG_ctrl_rx_rst,
  output logic       PROT_CFG_ctrl_frame_done,
  output logic [2:0] PROT_CFG_ctrl_err,
  input  logic       USR_PROT_ctrl_err_clr
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  rx_state_e   state;
  logic [LW-1:0] len;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo_tc;
  logic        is_stop;
  logic        hit;

  assign tmo_en  = (state == RECV) || (state == DROP);
  assign tmo_clr = !CFG_PROT_ctrl_Rxen
                || CORE_PROT_w_en
                || !tmo_en;
  assign is_stop = CORE_PROT_data_rx_data
                == CFG_PROT_data_stop_frame;
  assign hit = addr_hit(CORE_PROT_data_rx_data,
                        CFG_PROT_data_self_addr,
                        BCAST_ADDR);

  uart_rx_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .glb_clk (glb_clk),
    .glb_rstn(glb_rstn),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .tc      (tmo_tc)
  );

  // Frame FSM with registered FIFO strobes and error flags
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state                    <= IDLE;
      len                      <= '0;
      PROT_CFG_ctrl_rx_w_en    <= 1'b0;
      PROT_CFG_data_rx_data    <= '0;
      PROT_CFG_ctrl_rx_rst     <= 1'b0;
      PROT_CFG_ctrl_frame_done <= 1'b0;
      PROT_CFG_ctrl_err        <= '0;
    end else begin
      PROT_CFG_ctrl_rx_w_en    <= 1'b0;
      PROT_CFG_ctrl_rx_rst     <= 1'b0;
      PROT_CFG_ctrl_frame_done <= 1'b0;
      // later error sets override this clear
      if (USR_PROT_ctrl_err_clr) begin
        PROT_CFG_ctrl_err <= '0;
      end
      if (!CFG_PROT_ctrl_Rxen) begin
        state <= IDLE;
        len   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state                <= FLUSH;
            PROT_CFG_ctrl_rx_rst <= 1'b1;
          end
          FLUSH: begin
            state <= WAIT_ADDR;
          end
          WAIT_ADDR, DONE: begin
            if (CORE_PROT_w_en && hit) begin
              state <= RECV;
              len   <= '0;
            end else if (CORE_PROT_w_en) begin
              state <= DROP;
            end else begin
              state <= WAIT_ADDR;
            end
          end
          RECV: begin
            if (CORE_PROT_w_en && is_stop) begin
              state                    <= DONE;
              PROT_CFG_ctrl_frame_done <= 1'b1;
            end else if (CORE_PROT_w_en
                         && (len == LEN_MAX)) begin
              PROT_CFG_ctrl_err[ERR_LEN] <= 1'b1;
              state                      <= DROP;
            end else if (CORE_PROT_w_en
                         && Rx_FIFO_full) begin
              PROT_CFG_ctrl_err[ERR_OVF] <= 1'b1;
            end else if (CORE_PROT_w_en) begin
              PROT_CFG_ctrl_rx_w_en <= 1'b1;
              PROT_CFG_data_rx_data <=
                CORE_PROT_data_rx_data;
              len <= len + 1'b1;
            end else if (tmo_tc) begin
              PROT_CFG_ctrl_err[ERR_TMO] <= 1'b1;
              state                      <= WAIT_ADDR;
            end
          end
          DROP: begin
            if (CORE_PROT_w_en && is_stop) begin
              state <= WAIT_ADDR;
            end else if (!CORE_PROT_w_en && tmo_tc) begin
              PROT_CFG_ctrl_err[ERR_TMO] <= 1'b1;
              state                      <= WAIT_ADDR;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_protocal_rx_stm.sv
// Directed bench for uart_protocal_rx_stm with a
// push scoreboard (data plus expected cycle).
module tb_uart_protocal_rx_stm;
  import uart_prot_pkg::*;

  logic       glb_clk = 1'b0;
  logic       glb_rstn = 1'b0;
  logic       rxen = 1'b0;
  logic [7:0] self_addr = 8'h12;
  logic [7:0] stop_b = 8'h4F;
  logic       w_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_w_en;
  logic [7:0] rx_data;
  logic       rx_rst;
  logic       frame_done;
  logic [2:0] err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  uart_protocal_rx_stm #(
    .BCAST_ADDR (8'hFF),
    .MAX_LEN    (3),
    .TIMEOUT_CYC(16)
  ) dut (
    .glb_clk                 (glb_clk),
    .glb_rstn                (glb_rstn),
    .CFG_PROT_ctrl_Rxen      (rxen),
    .CFG_PROT_data_self_addr (self_addr),
    .CFG_PROT_data_stop_frame(stop_b),
    .CORE_PROT_w_en          (w_en),
    .CORE_PROT_data_rx_data  (din),
    .Rx_FIFO_full            (full),
    .PROT_CFG_ctrl_rx_w_en   (rx_w_en),
    .PROT_CFG_data_rx_data   (rx_data),
    .PROT_CFG_ctrl_rx_rst    (rx_rst),
    .PROT_CFG_ctrl_frame_done(frame_done),
    .PROT_CFG_ctrl_err       (err),
    .USR_PROT_ctrl_err_clr   (err_clr)
  );

  always #5 glb_clk = ~glb_clk;

  always @(posedge glb_clk) cyc <= cyc + 1;

  always @(negedge glb_clk) begin
    if (rx_rst) rst_cnt++;
    if (frame_done) done_cnt++;
    if (rx_w_en) begin
      push_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL push_unexp obs=%h exp=none",
               rx_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (rx_data === e.d && cyc == e.c)
        else begin
          errors++;
          $error("FAIL push obs=%h@%0d exp=%h@%0d",
                 rx_data, cyc, e.d, e.c);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b,
                        input logic push,
                        input logic f,
                        input logic c);
    @(negedge glb_clk);
    w_en = 1'b1;
    din = b;
    full = f;
    err_clr = c;
    if (push) sb.push_back('{b, cyc + 1});
    @(negedge glb_clk);
    w_en = 1'b0;
    full = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic push);
    strobe(b, push, 1'b0, 1'b0);
    repeat (2) @(negedge glb_clk);
  endtask

  task automatic clear_err();
    @(negedge glb_clk);
    err_clr = 1'b1;
    @(negedge glb_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge glb_clk);
    chk("rst_state", dut.state, IDLE);
    chk("rst_outs",
        {rx_w_en, rx_data, rx_rst, frame_done, err},
        '0);
    glb_rstn = 1'b1;
    repeat (2) @(negedge glb_clk);
    chk("idle_hold", dut.state, IDLE);

    // basic frame
    rxen = 1'b1;
    repeat (4) @(negedge glb_clk);
    chk("flush_once", rst_cnt, 1);
    send(8'h12, 1'b0);
    send(8'h05, 1'b1);
    send(8'h06, 1'b1);
    send(8'h07, 1'b1);
    send(8'h4F, 1'b0);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", err, 3'b000);

    // foreign frame then broadcast
    send(8'h13, 1'b0);
    send(8'h05, 1'b0);
    send(8'h4F, 1'b0);
    chk("t2_nodone", done_cnt, 1);
    send(8'hFF, 1'b0);
    send(8'h0A, 1'b1);
    send(8'h4F, 1'b0);
    chk("t2_done", done_cnt, 2);

    // overflow on second payload byte
    send(8'h12, 1'b0);
    send(8'h01, 1'b1);
    strobe(8'h02, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge glb_clk);
    send(8'h03, 1'b1);
    send(8'h4F, 1'b0);
    chk("t3_err", err, 3'b001);
    chk("t3_done", done_cnt, 3);

    // length overrun (MAX_LEN = 3)
    send(8'h12, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b0);
    send(8'h4F, 1'b0);
    chk("t4_err", err, 3'b011);
    chk("t4_nodone", done_cnt, 3);
    send(8'h12, 1'b0);
    send(8'h09, 1'b1);
    send(8'h4F, 1'b0);
    chk("t4_recover", done_cnt, 4);
    clear_err();
    chk("clr_err", err, 3'b000);

    // inter-byte timeout (TIMEOUT_CYC = 16)
    send(8'h12, 1'b0);
    strobe(8'h01, 1'b1, 1'b0, 1'b0);
    repeat (15) @(negedge glb_clk);
    chk("tmo_early", err[ERR_TMO], 1'b0);
    @(negedge glb_clk);
    chk("tmo_set", err[ERR_TMO], 1'b1);
    chk("tmo_state", dut.state, WAIT_ADDR);
    repeat (4) @(negedge glb_clk);
    send(8'h12, 1'b0);
    send(8'h02, 1'b1);
    send(8'h4F, 1'b0);
    chk("tmo_done", done_cnt, 5);

    // Rxen drop mid-payload
    send(8'h12, 1'b0);
    strobe(8'h05, 1'b1, 1'b0, 1'b0);
    rxen = 1'b0;
    repeat (2) @(negedge glb_clk);
    chk("dis_state", dut.state, IDLE);
    chk("dis_err_kept", err, 3'b100);
    rxen = 1'b1;
    repeat (3) @(negedge glb_clk);
    chk("reflush", rst_cnt, 2);
    send(8'h12, 1'b0);
    send(8'h07, 1'b1);
    send(8'h4F, 1'b0);
    chk("reen_done", done_cnt, 6);

    // err_clr colliding with overflow
    send(8'h12, 1'b0);
    strobe(8'h33, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge glb_clk);
    chk("clr_vs_ovf", err, 3'b001);
    send(8'h4F, 1'b0);
    chk("clr_done", done_cnt, 7);

    repeat (3) @(negedge glb_clk);
    chk("sb_empty", sb.size(), 0);
    chk("push_total", push_cnt, 14);
    chk("flush_total", rst_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
